serial_comparator_framed: RTL and testbench

Digit-serial magnitude comparator for two operands of WORD_W bits. Each accepted cycle delivers a DIGIT_W-bit digit of each operand. Digit order (MSB-first or LSB-first) is set by parameter, and signed/unsigned mode is selected per word. The block counts digits to find word boundaries and emits one registered, validated result per word. It sits behind serialising links and feeds control logic that needs a per-word compare verdict.

---
 rtl/serial_comparator_framed.sv | 167 ++++++++++++++++
 tb/tb_serial_comparator_framed.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_comparator_framed.sv
// serial_comparator_framed
//   Digit-serial magnitude comparator. Two WORD_W-bit operands arrive one
//   DIGIT_W-bit digit per accepted cycle. Digit order is set by MSB_FIRST.
//   Signed or unsigned mode is chosen per word. One registered verdict is
//   produced per word, one clock after the word's last digit.
//
// Parameters
//   DIGIT_W    bits of each operand per accepted cycle
//   WORD_W     operand width; must be a multiple of DIGIT_W
//   MSB_FIRST  1 = most significant digit first, 0 = least significant first
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous reset, active-high
//   in_valid     a/b/signed_mode carry a digit this cycle (always accepted)
//   a, b         operand digits
//   signed_mode  two's-complement compare; sampled on the first digit only
//   res_valid    one-cycle pulse when the verdict flags update
//   a_less_b     registered verdict A <  B
//   a_eq_b       registered verdict A == B
//   a_greater_b  registered verdict A >  B
module serial_comparator_framed #(
  parameter int DIGIT_W   = 1,
  parameter int WORD_W    = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               signed_mode,
  output logic               res_valid,
  output logic               a_less_b,
  output logic               a_eq_b,
  output logic               a_greater_b
);

  localparam int NDIG  = WORD_W / DIGIT_W;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  typedef enum logic [1:0] {
    ST_EQ      = 2'd0,
    ST_LESS    = 2'd1,
    ST_GREATER = 2'd2
  } cmp_state_t;

  // Registered state
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  cmp_state_t       state_reg, state_next;
  logic             mode_reg,  mode_next;
  logic             res_valid_reg, res_valid_next;
  logic             lt_reg, lt_next;
  logic             eq_reg, eq_next;
  logic             gt_reg, gt_next;

  // Per-digit evaluation
  logic               first_digit;
  logic               last_digit;
  logic               mode_eff;
  logic               sign_digit;
  logic [DIGIT_W-1:0] flip_mask;
  logic [DIGIT_W-1:0] a_cmp;
  logic [DIGIT_W-1:0] b_cmp;
  cmp_state_t         prior_state;
  cmp_state_t         digit_state;
  cmp_state_t         word_state;

  assign first_digit = (cnt_reg == '0);
  assign last_digit  = (cnt_reg == LAST_CNT);

  // The latched mode is not yet valid on the first digit, so use the live input there.
  assign mode_eff    = first_digit ? signed_mode : mode_reg;
  assign sign_digit  = (MSB_FIRST != 0) ? first_digit : last_digit;

  // Inverting the sign bit of both digits maps two's-complement ordering
  // onto unsigned ordering for that digit.
  always_comb begin
    flip_mask = '0;
    flip_mask[DIGIT_W-1] = sign_digit & mode_eff;
  end

  assign a_cmp = a ^ flip_mask;
  assign b_cmp = b ^ flip_mask;

  // A new word always starts from EQ, regardless of what the last word left behind.
  assign prior_state = first_digit ? ST_EQ : state_reg;

  always_comb begin
    digit_state = ST_EQ;
    if (a_cmp < b_cmp) begin
      digit_state = ST_LESS;
    end else if (a_cmp > b_cmp) begin
      digit_state = ST_GREATER;
    end
  end

  // MSB-first: the first unequal digit decides and later digits cannot change it.
  // LSB-first: each more significant unequal digit overrides what came before.
  always_comb begin
    word_state = prior_state;
    if (MSB_FIRST != 0) begin
      if (prior_state == ST_EQ) begin
        word_state = digit_state;
      end
    end else begin
      if (digit_state != ST_EQ) begin
        word_state = digit_state;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg       <= '0;
      state_reg     <= ST_EQ;
      mode_reg      <= 1'b0;
      res_valid_reg <= 1'b0;
      lt_reg        <= 1'b0;
      eq_reg        <= 1'b1;
      gt_reg        <= 1'b0;
    end else begin
      cnt_reg       <= cnt_next;
      state_reg     <= state_next;
      mode_reg      <= mode_next;
      res_valid_reg <= res_valid_next;
      lt_reg        <= lt_next;
      eq_reg        <= eq_next;
      gt_reg        <= gt_next;
    end
  end

  // Next-state logic
  always_comb begin
    cnt_next   = cnt_reg;
    state_next = state_reg;
    mode_next  = mode_reg;
    if (in_valid) begin
      cnt_next   = last_digit ? '0 : cnt_reg + CNT_W'(1);
      state_next = last_digit ? ST_EQ : word_state;
      if (first_digit) begin
        mode_next = signed_mode;
      end
    end
  end

  // Output logic: verdict flags update only on a word's last digit, otherwise hold
  always_comb begin
    res_valid_next = in_valid & last_digit;
    lt_next        = lt_reg;
    eq_next        = eq_reg;
    gt_next        = gt_reg;
    if (in_valid && last_digit) begin
      lt_next = (word_state == ST_LESS);
      eq_next = (word_state == ST_EQ);
      gt_next = (word_state == ST_GREATER);
    end
  end

  assign res_valid   = res_valid_reg;
  assign a_less_b    = lt_reg;
  assign a_eq_b      = eq_reg;
  assign a_greater_b = gt_reg;

endmodule

// File: tb/tb_serial_comparator_framed.sv
// Testbench for serial_comparator_framed. Three instances share one clock:
//   u1: DIGIT_W=1, WORD_W=8, MSB first
//   u4: DIGIT_W=4, WORD_W=8, LSB first
//   u8: DIGIT_W=8, WORD_W=8 (one digit per word)
// Expected verdicts come from a whole-word integer model. They are queued
// with the cycle they must appear in, then popped by per-instance monitors.
module tb_serial_comparator_framed;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       v1, sm1, rv1, lt1, eq1, gt1;
  logic [0:0] a1, b1;
  logic       v4, sm4, rv4, lt4, eq4, gt4;
  logic [3:0] a4, b4;
  logic       v8, sm8, rv8, lt8, eq8, gt8;
  logic [7:0] a8, b8;

  serial_comparator_framed #(.DIGIT_W(1), .WORD_W(8), .MSB_FIRST(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1), .signed_mode(sm1),
    .res_valid(rv1), .a_less_b(lt1), .a_eq_b(eq1), .a_greater_b(gt1));

  serial_comparator_framed #(.DIGIT_W(4), .WORD_W(8), .MSB_FIRST(0)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .signed_mode(sm4),
    .res_valid(rv4), .a_less_b(lt4), .a_eq_b(eq4), .a_greater_b(gt4));

  serial_comparator_framed #(.DIGIT_W(8), .WORD_W(8), .MSB_FIRST(1)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8), .signed_mode(sm8),
    .res_valid(rv8), .a_less_b(lt8), .a_eq_b(eq8), .a_greater_b(gt8));

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] flags;  // {lt, eq, gt}
    int         cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  exp_t q8[$];

  task automatic check_val(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] model(input logic [7:0] x, input logic [7:0] y, input logic sm);
    int ix, iy;
    if (sm) begin
      ix = int'($signed(x));
      iy = int'($signed(y));
    end else begin
      ix = int'(x);
      iy = int'(y);
    end
    return {ix < iy, ix == iy, ix > iy};
  endfunction

  // Monitors: every res_valid must match the head of its queue, in the expected cycle.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rv1) begin
      if (q1.size() == 0) begin
        check_val("u1 spurious res_valid", 1, 0);
      end else begin
        e = q1.pop_front();
        $display("u1 result lt=%0d eq=%0d gt=%0d cyc=%0d", lt1, eq1, gt1, cyc);
        check_val("u1 flags", int'({lt1, eq1, gt1}), int'(e.flags));
        check_val("u1 result cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon4
    exp_t e;
    if (rv4) begin
      if (q4.size() == 0) begin
        check_val("u4 spurious res_valid", 1, 0);
      end else begin
        e = q4.pop_front();
        $display("u4 result lt=%0d eq=%0d gt=%0d cyc=%0d", lt4, eq4, gt4, cyc);
        check_val("u4 flags", int'({lt4, eq4, gt4}), int'(e.flags));
        check_val("u4 result cycle", cyc, e.cyc);
      end
    end
  end

  always @(negedge clk) begin : mon8
    exp_t e;
    if (rv8) begin
      if (q8.size() == 0) begin
        check_val("u8 spurious res_valid", 1, 0);
      end else begin
        e = q8.pop_front();
        $display("u8 result lt=%0d eq=%0d gt=%0d cyc=%0d", lt8, eq8, gt8, cyc);
        check_val("u8 flags", int'({lt8, eq8, gt8}), int'(e.flags));
        check_val("u8 result cycle", cyc, e.cyc);
      end
    end
  end

  // Sends ndig digits MSB first. A gap of gap_len idle cycles is inserted
  // before digit index gap_at. Later digits carry a toggled or random signed_mode.
  task automatic send1(input logic [7:0] x, input logic [7:0] y, input logic sm,
                       input int ndig, input int gap_at, input int gap_len, input bit toggle);
    exp_t e;
    for (int i = 0; i < ndig; i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(negedge clk);
          v1  = 1'b0;
          a1  = 1'($urandom);
          b1  = 1'($urandom);
          sm1 = 1'($urandom);
        end
      end
      @(negedge clk);
      v1  = 1'b1;
      a1  = x[7-i];
      b1  = y[7-i];
      sm1 = (i == 0) ? sm : (toggle ? ~sm : 1'($urandom));
      if (i == 7) begin
        e.flags = model(x, y, sm);
        e.cyc   = cyc + 1;
        q1.push_back(e);
      end
    end
  endtask

  task automatic send4(input logic [7:0] x, input logic [7:0] y, input logic sm);
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      v4  = 1'b1;
      a4  = (i == 0) ? x[3:0] : x[7:4];
      b4  = (i == 0) ? y[3:0] : y[7:4];
      sm4 = (i == 0) ? sm : 1'($urandom);
    end
    e.flags = model(x, y, sm);
    e.cyc   = cyc + 1;
    q4.push_back(e);
  endtask

  task automatic send8(input logic [7:0] x, input logic [7:0] y, input logic sm);
    exp_t e;
    @(negedge clk);
    v8  = 1'b1;
    a8  = x;
    b8  = y;
    sm8 = sm;
    e.flags = model(x, y, sm);
    e.cyc   = cyc + 1;
    q8.push_back(e);
  endtask

  task automatic idle_all(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      v1 = 1'b0; a1 = 1'($urandom); b1 = 1'($urandom); sm1 = 1'($urandom);
      v4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); sm4 = 1'($urandom);
      v8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); sm8 = 1'($urandom);
    end
  endtask

  initial begin
    rst = 1'b1;
    v1 = 1'b0; a1 = '0; b1 = '0; sm1 = 1'b0;
    v4 = 1'b0; a4 = '0; b4 = '0; sm4 = 1'b0;
    v8 = 1'b0; a8 = '0; b8 = '0; sm8 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("reset u1 res_valid", int'(rv1), 0);
    check_val("reset u1 flags", int'({lt1, eq1, gt1}), 3'b010);
    check_val("reset u4 flags", int'({lt4, eq4, gt4}), 3'b010);
    check_val("reset u8 flags", int'({lt8, eq8, gt8}), 3'b010);
    rst = 1'b0;

    // Bit-serial MSB-first: unsigned, equal, signed vs unsigned, mode toggling
    send1(8'h5A, 8'h5B, 1'b0, 8, -1, 0, 1'b0);
    send1(8'hC3, 8'hC3, 1'b0, 8, -1, 0, 1'b0);
    send1(8'h80, 8'h01, 1'b1, 8, -1, 0, 1'b0);
    send1(8'h80, 8'h01, 1'b0, 8, -1, 0, 1'b0);
    send1(8'h80, 8'h01, 1'b1, 8, -1, 0, 1'b1);
    send1(8'h80, 8'h01, 1'b0, 8, -1, 0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      send1(8'($urandom), 8'($urandom), 1'($urandom), 8, -1, 0, 1'b0);
    end
    idle_all(3);

    // Gap of 3 idle cycles between digits 4 and 5, then flags must hold
    send1(8'h01, 8'h02, 1'b0, 8, 4, 3, 1'b0);
    idle_all(5);
    check_val("u1 hold a_less_b", int'(lt1), 1);
    check_val("u1 hold a_greater_b", int'(gt1), 0);

    // Reset mid-word discards the partial word
    send1(8'hFF, 8'h00, 1'b0, 3, -1, 0, 1'b0);
    @(negedge clk);
    v1  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_val("mid-word reset u1 flags", int'({lt1, eq1, gt1}), 3'b010);
    check_val("mid-word reset u1 res_valid", int'(rv1), 0);
    idle_all(2);

    // Back-to-back words, no bubble
    send1(8'h10, 8'h10, 1'b0, 8, -1, 0, 1'b0);
    send1(8'h20, 8'h10, 1'b0, 8, -1, 0, 1'b0);
    idle_all(3);

    // Nibble-serial LSB-first
    send4(8'h3C, 8'h4C, 1'b0);
    send4(8'h41, 8'h3F, 1'b0);
    send4(8'hF0, 8'h10, 1'b1);
    send4(8'hF0, 8'h10, 1'b0);
    send4(8'h7F, 8'h80, 1'b1);
    send4(8'h5A, 8'h5A, 1'b1);
    idle_all(3);

    // One digit per word
    send8(8'h80, 8'h7F, 1'b1);
    send8(8'h80, 8'h7F, 1'b0);
    send8(8'h55, 8'h55, 1'b0);
    send8(8'hFE, 8'hFF, 1'b1);
    idle_all(5);

    // Every queued verdict must have appeared
    check_val("u1 results outstanding", q1.size(), 0);
    check_val("u4 results outstanding", q4.size(), 0);
    check_val("u8 results outstanding", q8.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
